// File: rtl/tm1638_pkg.sv
// Shared types for the TM1638 key event path.
// Event payload carried from the drain logic through the FIFO.
package tm1638_pkg;

  localparam int KEY_IDX_W = 4;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_REPEAT  = 2'd2
  } key_evt_t;

  typedef struct packed {
    logic [KEY_IDX_W-1:0] key;
    key_evt_t             typ;
  } key_evt_s;

endpackage

// File: rtl/tm1638_evt_fifo.sv
// Small synchronous FIFO for key events.
// Pointers carry one wrap bit so full and empty are distinct.
module tm1638_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees the slot, so a push into a full FIFO may go ahead
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tm1638_key_events.sv
// Debounce, edge detect and auto-repeat for TM1638 keys,
// delivering typed events through a valid/ready FIFO.
module tm1638_key_events #(
  parameter int clk_mhz          = 50,
  parameter int w_key            = 8,
  parameter int sample_us        = 1000,
  parameter int debounce_samples = 8,
  parameter int repeat_delay     = 500,
  parameter int repeat_period    = 100,
  parameter int fifo_depth       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [w_key-1:0]         keys,
  output logic [w_key-1:0]         keys_stable,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(w_key)-1:0] evt_key,
  output logic [1:0]               evt_type,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  import tm1638_pkg::*;

  localparam int KW    = $clog2(w_key);
  localparam int PRE_N = clk_mhz * sample_us;
  localparam int PW    = (PRE_N > 1) ? $clog2(PRE_N) : 1;
  localparam int CW    = $clog2(debounce_samples + 1);
  localparam int RW    = (repeat_delay > 0) ?
                         $clog2(repeat_delay + 1) : 1;

  logic [PW-1:0]             pre_q, pre_d;
  logic                      tick;
  logic [w_key-1:0]          stable_q, stable_d;
  logic [w_key-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [w_key-1:0]          press_q, press_d;
  logic [w_key-1:0]          rel_q, rel_d;
  logic [w_key-1:0]          press_set, rel_set;
  logic [w_key-1:0]          press_clr, rel_clr;
  logic [KW-1:0]             rpt_key_q, rpt_key_d;
  logic [RW-1:0]             rpt_cnt_q, rpt_cnt_d;
  logic                      rpt_active_q, rpt_active_d;
  logic                      rpt_pend_q, rpt_pend_d;
  logic                      rpt_set, rpt_clr;
  logic                      overflow_q, overflow_d;
  logic                      push, pop, full, empty;
  key_evt_s                  push_evt, head_evt;

  assign tick = (pre_q == PW'(PRE_N - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_comb begin
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_set = '0;
    rel_set   = '0;
    if (tick) begin
      for (int k = 0; k < w_key; k++) begin
        if (keys[k] != stable_q[k]) begin
          if (32'(cnt_q[k]) + 1 == debounce_samples) begin
            stable_d[k]  = keys[k];
            cnt_d[k]     = '0;
            press_set[k] = keys[k];
            rel_set[k]   = !keys[k];
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end else begin
          cnt_d[k] = '0;
        end
      end
    end
  end

  always_comb begin
    rpt_key_d    = rpt_key_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_active_d = rpt_active_q;
    rpt_set      = 1'b0;
    if (tick && rpt_active_q && stable_q[rpt_key_q] &&
        !rel_set[rpt_key_q]) begin
      if (32'(rpt_cnt_q) + 1 == repeat_delay) begin
        rpt_set   = 1'b1;
        rpt_cnt_d = RW'(repeat_delay - repeat_period);
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
    if (rel_set[rpt_key_q]) rpt_active_d = 1'b0;
    // Ascending scan: the highest index pressed this tick owns repeat
    if (repeat_delay > 0) begin
      for (int k = 0; k < w_key; k++) begin
        if (press_set[k]) begin
          rpt_key_d    = KW'(k);
          rpt_cnt_d    = '0;
          rpt_active_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    push      = 1'b0;
    push_evt  = '0;
    press_clr = '0;
    rel_clr   = '0;
    rpt_clr   = 1'b0;
    if (rpt_pend_q) begin
      push         = 1'b1;
      rpt_clr      = 1'b1;
      push_evt.key = KEY_IDX_W'(rpt_key_q);
      push_evt.typ = EVT_REPEAT;
    end else if (|press_q) begin
      push         = 1'b1;
      push_evt.typ = EVT_PRESS;
      for (int k = w_key - 1; k >= 0; k--) begin
        if (press_q[k]) begin
          push_evt.key = KEY_IDX_W'(k);
          press_clr    = '0;
          press_clr[k] = 1'b1;
        end
      end
    end else if (|rel_q) begin
      push         = 1'b1;
      push_evt.typ = EVT_RELEASE;
      for (int k = w_key - 1; k >= 0; k--) begin
        if (rel_q[k]) begin
          push_evt.key = KEY_IDX_W'(k);
          rel_clr      = '0;
          rel_clr[k]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    press_d    = (press_q & ~press_clr) | press_set;
    rel_d      = (rel_q & ~rel_clr) | rel_set;
    rpt_pend_d = (rpt_pend_q && !rpt_clr) || rpt_set;
    overflow_d = overflow_q;
    if (push && full && !pop) overflow_d = 1'b1;
    else if (overflow_clr)    overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      stable_q     <= '0;
      cnt_q        <= '0;
      press_q      <= '0;
      rel_q        <= '0;
      rpt_key_q    <= '0;
      rpt_cnt_q    <= '0;
      rpt_active_q <= 1'b0;
      rpt_pend_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
      rel_q        <= rel_d;
      rpt_key_q    <= rpt_key_d;
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_active_q <= rpt_active_d;
      rpt_pend_q   <= rpt_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  assign pop = !empty && evt_ready;

  tm1638_evt_fifo #(
    .DEPTH (fifo_depth),
    .W     ($bits(key_evt_s))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head_evt),
    .full      (full),
    .empty     (empty)
  );

  if (KW < KEY_IDX_W) begin : g_key_hi
    logic unused_key_hi;
    assign unused_key_hi = ^head_evt.key[KEY_IDX_W-1:KW];
  end

  assign keys_stable = stable_q;
  assign evt_valid   = !empty;
  assign evt_key     = head_evt.key[KW-1:0];
  assign evt_type    = head_evt.typ;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_tm1638_key_events.sv
// Directed bench for tm1638_key_events with a scoreboard
// of expected events checked by an independent monitor.
module tb_tm1638_key_events;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] keys = '0;
  logic [7:0] keys_stable;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [2:0] evt_key;
  logic [1:0] evt_type;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  always #5 clk = ~clk;

  tm1638_key_events #(
    .clk_mhz          (1),
    .w_key            (8),
    .sample_us        (10),
    .debounce_samples (3),
    .repeat_delay     (5),
    .repeat_period    (2),
    .fifo_depth       (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .keys         (keys),
    .keys_stable  (keys_stable),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_key      (evt_key),
    .evt_type     (evt_type),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  typedef struct packed {
    logic [2:0] key;
    logic [1:0] typ;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   edge_i = -1;

  localparam logic [1:0] P = 2'd0;
  localparam logic [1:0] R = 2'd1;
  localparam logic [1:0] T = 2'd2;

  // Edge index since reset release; ticks land on edges 9, 19, 29 ...
  always @(posedge clk) edge_i <= rst_n ? edge_i + 1 : -1;

  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got key %0d type %0d want none",
                 evt_key, evt_type);
      end else begin
        mon_e = sb.pop_front();
        if (evt_key !== mon_e.key || evt_type !== mon_e.typ) begin
          errors++;
          $display("FAIL evt_order: got key %0d type %0d want key %0d type %0d",
                   evt_key, evt_type, mon_e.key, mon_e.typ);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input int k, input logic [1:0] t);
    sb.push_back({3'(k), t});
  endtask

  task automatic at_edge(input int n);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL at_edge_timeout: got edge %0d want %0d", edge_i, n);
        $fatal(1, "edge wait expired");
      end
    end while (edge_i < n);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_stable"}, 32'(keys_stable), 32'h0);
    chk({name, "_valid"}, 32'(evt_valid), 32'h0);
    chk({name, "_ovf"}, 32'(overflow), 32'h0);
    chk({name, "_head"}, 32'({evt_key, evt_type}), 32'h0);
  endtask

  task automatic do_reset(input logic [7:0] k);
    rst_n = 1'b0;
    keys  = k;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int bad;

  initial begin
    // clean press then release of key 2
    do_reset(8'h04);
    expect_evt(2, P);
    expect_evt(2, R);
    at_edge(28); chk("t1_pre_flip", 32'(keys_stable), 32'h00);
    at_edge(29); chk("t1_flip", 32'(keys_stable), 32'h04);
    chk("t1_valid_lat0", 32'(evt_valid), 32'h0);
    at_edge(30); chk("t1_valid_lat1", 32'(evt_valid), 32'h1);
    chk("t1_head", 32'({evt_key, evt_type}), {27'd0, 3'd2, P});
    keys = 8'h00;
    at_edge(58); chk("t1_pre_rel", 32'(keys_stable), 32'h04);
    at_edge(59); chk("t1_rel", 32'(keys_stable), 32'h00);
    at_edge(65); chk("t1_sb_empty", 32'(sb.size()), 32'h0);

    // bouncing key 2 never settles
    do_reset(8'h04);
    at_edge(9);  keys = 8'h00;
    at_edge(19); keys = 8'h04;
    at_edge(29); keys = 8'h00;
    at_edge(39); keys = 8'h04;
    at_edge(49); keys = 8'h00;
    at_edge(60); chk("t2_stable", 32'(keys_stable), 32'h00);
    chk("t2_valid", 32'(evt_valid), 32'h0);

    // key 5 held: repeats at +5, +7, +9, +11 ticks
    do_reset(8'h20);
    expect_evt(5, P);
    for (int i = 0; i < 4; i++) expect_evt(5, T);
    expect_evt(5, R);
    at_edge(80);
    chk("t3_first_rpt", 32'({evt_valid, evt_key, evt_type}),
        {26'd0, 1'b1, 3'd5, T});
    at_edge(119); keys = 8'h00;
    at_edge(160); chk("t3_sb_empty", 32'(sb.size()), 32'h0);

    // keys 0 and 3 on the same tick; repeat follows key 3
    do_reset(8'h09);
    expect_evt(0, P);
    expect_evt(3, P);
    expect_evt(3, T);
    expect_evt(3, T);
    expect_evt(0, R);
    expect_evt(3, R);
    at_edge(30); chk("t4_first", 32'(evt_key), 32'd0);
    at_edge(31); chk("t4_second", 32'(evt_key), 32'd3);
    at_edge(79); keys = 8'h00;
    at_edge(120); chk("t4_sb_empty", 32'(sb.size()), 32'h0);

    // five presses into a four-deep FIFO with the consumer stalled
    evt_ready = 1'b0;
    do_reset(8'h57);
    expect_evt(0, P);
    expect_evt(1, P);
    expect_evt(2, P);
    expect_evt(4, P);
    expect_evt(6, T);
    at_edge(33); chk("t5_ovf_before", 32'(overflow), 32'h0);
    at_edge(34); chk("t5_ovf_set", 32'(overflow), 32'h1);
    at_edge(40); overflow_clr = 1'b1;
    at_edge(41); overflow_clr = 1'b0;
    chk("t5_ovf_clr", 32'(overflow), 32'h0);
    at_edge(44);
    chk("t5_head_hold", 32'({evt_valid, evt_key, evt_type}),
        {26'd0, 1'b1, 3'd0, P});
    at_edge(45); evt_ready = 1'b1;
    at_edge(85);
    chk("t5_sb_empty", 32'(sb.size()), 32'h0);
    evt_ready = 1'b0;

    // async reset with repeat live, FIFO occupied, debounce mid-count
    at_edge(100); keys = 8'h00;
    at_edge(101); chk("t6_fifo_busy", 32'(evt_valid), 32'h1);
    at_edge(112);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async");
    evt_ready = 1'b1;
    do_reset(8'h02);
    expect_evt(1, P);
    bad = 0;
    for (int e = 0; e < 28; e++) begin
      at_edge(e);
      if (evt_valid !== 1'b0) bad++;
    end
    chk("t6_no_stale", 32'(bad), 32'h0);
    at_edge(28); chk("t6_pre_tick3", 32'(keys_stable), 32'h00);
    at_edge(29); chk("t6_tick3", 32'(keys_stable), 32'h02);
    at_edge(40); chk("t6_sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tm1638_key_events.md
Name: tm1638_key_events

Overview:
- Downstream consumer of the TM1638 board controller's raw `keys` vector, which is refreshed once per scan and contains contact bounce.
- Debounces each key on a shared sample tick and detects press and release edges.
- Generates auto-repeat for the most recently pressed key.
- Queues typed key events in a small FIFO with a valid/ready handshake, so lab logic consumes clean single events instead of raw levels.

Parameters:
- clk_mhz, 50, system clock frequency in MHz.
- w_key, 8, number of keys (16 for the HCW-132 board variant).
- sample_us, 1000, sample tick period in µs; prescaler terminal count is clk_mhz*sample_us-1.
- debounce_samples, 8, number of consecutive differing samples needed to flip a stable key; must be ≥1.
- repeat_delay, 500, ticks from press to first repeat; 0 disables auto-repeat.
- repeat_period, 100, ticks between repeats; must be ≥1 and ≤repeat_delay.
- fifo_depth, 4, event FIFO depth; must be a power of 2 and ≥2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- keys  input  w_key  raw key levels from the board controller, 1 = pressed, synchronous to clk.
- keys_stable  output  w_key  debounced key levels.
- evt_valid  output  1  FIFO head is valid.
- evt_ready  input  1  consumer accepts the head; pop occurs when evt_valid && evt_ready.
- evt_key  output  $clog2(w_key)  key index of the head event.
- evt_type  output  2  head event type: 0 = press, 1 = release, 2 = repeat; 3 is never produced.
- overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
- overflow_clr  input  1  clears `overflow`; a set in the same cycle wins.

Behaviour:
- Reset (asynchronous, rst_n=0): clears prescaler, all debounce counters, keys_stable, pending bits, repeat state, FIFO pointers, overflow. Outputs go to 0 immediately.
- Tick: single-cycle strobe when the prescaler reaches its terminal count; the prescaler then wraps to 0. The first tick occurs clk_mhz*sample_us cycles after reset release.
- Debounce, per key k, on each tick:
  - keys[k]!=keys_stable[k]: cnt[k]++.
  - keys[k]==keys_stable[k]: cnt[k]<=0.
  - When a differing sample would bring cnt[k] to debounce_samples: keys_stable[k] toggles, cnt[k]<=0, and press_pend[k] or rel_pend[k] is set in that same edge.
- Repeat tracker (rpt_key, rpt_cnt, rpt_active):
  - A press flip of key k loads rpt_key=k, rpt_cnt=0, rpt_active=1; the latest press wins.
  - On each tick while rpt_active && keys_stable[rpt_key]: rpt_cnt++.
  - When rpt_cnt would reach repeat_delay: set rpt_pend and load rpt_cnt<=repeat_delay-repeat_period.
  - A release flip of rpt_key clears rpt_active.
  - repeat_delay=0: rpt_active is never set.
- Drain: one event per clock, moved from pending bits into the FIFO.
  - Priority: rpt_pend first, then lowest-index press_pend, then lowest-index rel_pend.
  - The source pending bit clears when its event is pushed.
  - A drain and a new pending set for the same bit in the same cycle: the set wins.
- FIFO:
  - Push while full: the event is discarded, its pending bit is still cleared, and overflow<=1.
  - Push and pop in the same cycle while full are allowed; the push succeeds.
  - evt_valid = !empty; evt_key and evt_type hold the head and stay stable while valid && !ready.
  - Latency: a pending bit set at edge N is pushed at edge N+1 if it has priority, so evt_valid rises after edge N+1.
- Counter widths:
  - cnt: $clog2(debounce_samples+1).
  - rpt_cnt: $clog2(repeat_delay+1).
  - Prescaler: $clog2(clk_mhz*sample_us).
  - No counter saturates except via the reload rules above.
- keys changing between ticks is ignored; only levels sampled at a tick count.

Decomposition:
- Shared package tm1638_pkg holds:
  - enum key_evt_t {EVT_PRESS=0, EVT_RELEASE=1, EVT_REPEAT=2}.
  - struct key_evt_s {key index, key_evt_t}.
- One sub-module, tm1638_evt_fifo: parameterised depth and payload, synchronous FIFO with full/empty, push/pop, async active-low reset.

Test Plan (clk_mhz=1, sample_us=10 → tick every 10 cycles; debounce_samples=3, repeat_delay=5, repeat_period=2, fifo_depth=4):
- keys[2]=1 held → keys_stable[2]=1 at the 3rd tick (cycle 29 edge); evt {2, PRESS} is valid from the following cycle; releasing keys[2] gives {2, RELEASE} after 3 more ticks.
- keys[2] toggled 1,0,1 on alternate ticks → keys_stable stays 0 and no event is produced.
- keys[5]=1 held with evt_ready=1 → PRESS, then REPEAT events 5 and 7 ticks later, and every 2 ticks thereafter; REPEAT stops on the tick of the release flip.
- keys[0] and keys[3] pressed on the same tick, evt_ready=1 → {0, PRESS} then {3, PRESS} on consecutive cycles; repeats track key 3.
- evt_ready=0 with 5 press/release events generated → 4 events queued, overflow=1; overflow_clr pulse → overflow=0; draining returns the first 4 events in order.
- rst_n asserted mid-debounce, with a repeat active and the FIFO non-empty → all outputs 0 asynchronously; after release, the first tick occurs 10 cycles later and no stale event appears.
